// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM encoding, address-mux select values and
// default bus widths used by the RAM, datapath and controller.
package instr_fetch_unit_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_LOAD = 2'd3
  } fetch_state_e;

  localparam logic MSEL_PC   = 1'b0;
  localparam logic MSEL_DATA = 1'b1;

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter register: async reset, load priority branch > increment > hold.
module pc_register #(
  parameter int          ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc_en,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_val;
    end else if (inc_en) begin
      // Natural modulo-2^ADDR_W wrap from the top address back to zero.
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, muxes the RAM address and loads the instruction register.
// Optional FETCH_COUNT_EN adds a saturating count of completed fetches.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int RESET_PC = 0,
  parameter int MEM_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               data_req,
  input  logic [ADDR_W-1:0]  data_addr,
  input  logic [INSTR_W-1:0] mdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               msel,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic               busy,
  output logic [ADDR_W-1:0]  pc,
  output logic [1:0]         dbg_state
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]        fetch_count
`endif
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  // Handshake: fetch_req is taken only in IDLE; the fetch ends with a one-cycle
  // instr_valid pulse, and busy stays high from the accepting edge until then.

  fetch_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               pc_load, pc_inc;

  pc_register #(
    .ADDR_W    (ADDR_W),
    .RESET_VAL (ADDR_W'(RESET_PC))
  ) u_pc (
    .clk      (clk),
    .rst      (reset),
    .load_en  (pc_load),
    .load_val (branch_target),
    .inc_en   (pc_inc),
    .pc       (pc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pc_load = branch_en;
        if (fetch_req) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        cnt_d = CNT_W'(MEM_LAT - 1);
        if (!data_req) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A data access steals the RAM port, so the in-flight read is discarded.
        if (data_req) begin
          state_d = ST_ADDR;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          instr_d = mdata;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        pc_inc  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (state_q == ST_LOAD && fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign fetch_count = fcnt_q;
`endif

  assign mem_addr    = data_req ? data_addr : pc;
  assign msel        = data_req ? MSEL_DATA : MSEL_PC;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a registered RAM model and a
// PC/instruction reference model driven by randomized fetch/branch traffic.
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int MEM_LAT = 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               fetch_req = 1'b0;
  logic               branch_en = 1'b0;
  logic [ADDR_W-1:0]  branch_target = '0;
  logic               data_req = 1'b0;
  logic [ADDR_W-1:0]  data_addr = '0;
  logic [INSTR_W-1:0] mdata = '0;
  logic [ADDR_W-1:0]  mem_addr;
  logic               msel;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic               busy;
  logic [ADDR_W-1:0]  pc;
  logic [1:0]         dbg_state;
`ifdef FETCH_COUNT_EN
  logic [15:0]        fetch_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [ADDR_W-1:0]  pc_model;
  logic [INSTR_W-1:0] exp_q[$];
  logic [INSTR_W-1:0] ram [0:(1<<ADDR_W)-1];

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (0),
    .MEM_LAT  (MEM_LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_req     (fetch_req),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .data_req      (data_req),
    .data_addr     (data_addr),
    .mdata         (mdata),
    .mem_addr      (mem_addr),
    .msel          (msel),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .busy          (busy),
    .pc            (pc),
    .dbg_state     (dbg_state)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  // Clock and one-cycle-latency RAM model
  always #5 clk = ~clk;
  always @(posedge clk) mdata <= ram[mem_addr];

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if (pc !== 8'h00 || instruction !== 16'h0000 || instr_valid !== 1'b0 || busy !== 1'b0 ||
        mem_addr !== 8'h00 || msel !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset: pc=%h instr=%h valid=%b busy=%b addr=%h msel=%b st=%0d, want 00/0000/0/0/00/0/0",
               pc, instruction, instr_valid, busy, mem_addr, msel, dbg_state);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    pc_model = 8'h00;
  endtask

  // One fetch; optionally branches first, optionally toggles ignored inputs while busy.
  task automatic run_fetch(input logic br, input logic [ADDR_W-1:0] tgt, input logic noisy);
    logic [ADDR_W-1:0]  pe;
    logic [INSTR_W-1:0] ei;
    int k;
    bit seen;
    @(posedge clk); #1;
    fetch_req = 1'b1; branch_en = br; branch_target = tgt;
    pe = br ? tgt : pc_model;
    exp_q.push_back(ram[pe]);
    @(posedge clk); #1;
    fetch_req = noisy; branch_en = noisy; branch_target = 8'h77;
    k = 1; seen = 0;
    while (k < 20 && !seen) begin
      if (instr_valid) begin
        seen = 1;
      end else begin
        total++;
        if (mem_addr !== pe || msel !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL fetch_addr: cycle=%0d addr=%h msel=%b busy=%b, want %h/0/1", k, mem_addr, msel, busy, pe);
        end
        @(posedge clk); #1;
        k++;
      end
    end
    fetch_req = 1'b0; branch_en = 1'b0;
    total++;
    if (!seen || k != 2 + MEM_LAT) begin
      bad++;
      $display("FAIL fetch_latency: seen=%0d cycles=%0d, want %0d", seen, k, 2 + MEM_LAT);
    end
    ei = exp_q.pop_front();
    total++;
    if (instruction !== ei || pc !== pe) begin
      bad++;
      $display("FAIL fetch_load: instr=%h pc=%h, want %h/%h", instruction, pc, ei, pe);
    end
    @(posedge clk); #1;
    pc_model = pe + 8'd1;
    total++;
    if (pc !== pc_model || instr_valid !== 1'b0 || busy !== 1'b0 || instruction !== ei) begin
      bad++;
      $display("FAIL fetch_after: pc=%h valid=%b busy=%b instr=%h, want %h/0/0/%h",
               pc, instr_valid, busy, instruction, pc_model, ei);
    end
  endtask

  task automatic test_first_fetch();
    ram[0] = 16'hD105;
    run_fetch(1'b0, 8'h00, 1'b0);
    total++;
    if (instruction !== 16'hD105 || pc !== 8'h01) begin
      bad++;
      $display("FAIL first_fetch: instr=%h pc=%h, want d105/01", instruction, pc);
    end
  endtask

  task automatic test_branch_fetch();
    ram[8'h20] = 16'hA1A2;
    run_fetch(1'b1, 8'h20, 1'b0);
    total++;
    if (instruction !== 16'hA1A2 || pc !== 8'h21) begin
      bad++;
      $display("FAIL branch_fetch: instr=%h pc=%h, want a1a2/21", instruction, pc);
    end
  endtask

  task automatic test_wrap();
    run_fetch(1'b1, 8'hFF, 1'b0);
    total++;
    if (pc !== 8'h00) begin
      bad++;
      $display("FAIL wrap: pc=%h, want 00", pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_fetch(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_ignored_inputs();
    run_fetch(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_data_override();
    logic [ADDR_W-1:0] pe;
    int k;
    pe = pc_model;
    @(posedge clk); #1; fetch_req = 1'b1;
    @(posedge clk); #1; fetch_req = 1'b0;
    @(posedge clk); #1;
    data_req = 1'b1; data_addr = 8'h15;
    #1;
    total++;
    if (mem_addr !== 8'h15 || msel !== 1'b1) begin
      bad++;
      $display("FAIL override_mux: addr=%h msel=%b, want 15/1", mem_addr, msel);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (instr_valid !== 1'b0 || pc !== pe || busy !== 1'b1 || mem_addr !== 8'h15) begin
        bad++;
        $display("FAIL override_hold: valid=%b pc=%h busy=%b addr=%h, want 0/%h/1/15", instr_valid, pc, busy, mem_addr, pe);
      end
    end
    data_req = 1'b0;
    #1;
    total++;
    if (mem_addr !== pe || msel !== 1'b0) begin
      bad++;
      $display("FAIL override_release: addr=%h msel=%b, want %h/0", mem_addr, msel, pe);
    end
    // Counting the last data_req cycle as cycle 0, the pulse lands in cycle 2+MEM_LAT.
    k = 0;
    while (k < 20 && !instr_valid) begin
      @(posedge clk); #1;
      k++;
    end
    total++;
    if (k + 1 != 2 + MEM_LAT || instruction !== ram[pe] || pc !== pe) begin
      bad++;
      $display("FAIL override_refetch: cycles=%0d instr=%h pc=%h, want %0d/%h/%h", k + 1, instruction, pc, 2 + MEM_LAT, ram[pe], pe);
    end
    @(posedge clk); #1;
    pc_model = pe + 8'd1;
    total++;
    if (pc !== pc_model) begin
      bad++;
      $display("FAIL override_pc: pc=%h, want %h", pc, pc_model);
    end
  endtask

  task automatic test_reset_mid_fetch();
    run_fetch(1'b1, 8'h40, 1'b0);
    @(posedge clk); #1; fetch_req = 1'b1;
    @(posedge clk); #1; fetch_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    total++;
    if (pc !== 8'h00 || busy !== 1'b0 || instr_valid !== 1'b0 || dbg_state !== 2'd0 || mem_addr !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid: pc=%h busy=%b valid=%b st=%0d addr=%h, want 00/0/0/0/00", pc, busy, instr_valid, dbg_state, mem_addr);
    end
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    pc_model = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (instr_valid !== 1'b0 || instruction !== 16'h0000 || pc !== 8'h00) begin
        bad++;
        $display("FAIL reset_quiet: valid=%b instr=%h pc=%h, want 0/0000/00", instr_valid, instruction, pc);
      end
    end
  endtask

`ifdef FETCH_COUNT_EN
  task automatic test_fetch_count();
    test_reset();
    total++;
    if (fetch_count !== 16'd0) begin
      bad++;
      $display("FAIL count_reset: count=%0d, want 0", fetch_count);
    end
    for (int i = 0; i < 3; i++) run_fetch(1'b0, 8'h00, 1'b0);
    total++;
    if (fetch_count !== 16'd3) begin
      bad++;
      $display("FAIL count_three: count=%0d, want 3", fetch_count);
    end
    test_data_override();
    total++;
    if (fetch_count !== 16'd4) begin
      bad++;
      $display("FAIL count_override: count=%0d, want 4", fetch_count);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 16'($urandom);
    test_reset();
    test_first_fetch();
    test_branch_fetch();
    test_wrap();
    test_random();
    test_ignored_inputs();
    test_data_override();
    test_reset_mid_fetch();
`ifdef FETCH_COUNT_EN
    test_fetch_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
